// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_arb_pkg
//  Description : Shared types, constants and helpers for the FIFO write
//                arbiter (FSM state encoding, level width, log2 helper).
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    // Arbiter FSM state, explicit one-bit encoding.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Default FIFO address width and the matching level-counter width
    // (level must be able to hold DEPTH itself, hence one extra bit).
    localparam int DEFAULT_ADDR_WIDTH = 2;
    localparam int LVL_W              = DEFAULT_ADDR_WIDTH + 1;

    // Ceiling log2, never less than 1 so it can size a vector directly.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage : fifo_arb_pkg
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational rotating-priority encoder. Finds the first
//                asserted request scanning upward from ptr, wrapping modulo N.
//  Ports       : req   [N]   request vector
//                ptr   [PW]  index with highest priority (0..N-1)
//                found       at least one request asserted
//                idx   [PW]  winning requester index (valid when found)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          found,
    output logic [PW-1:0] idx
);

    int            c;
    logic [PW-1:0] cand;

    // Scan from the lowest priority offset down to offset 0 so that the
    // last hit written is the one closest to ptr.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        c     = 0;
        cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            c = int'(ptr) + k;
            if (c >= N) begin
                c = c - N;
            end
            cand = PW'(c);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arbiter
//  Description : Round-robin arbiter sharing one 8-bit FIFO write port among
//                N requesters. Packets are granted atomically (up to
//                BURST_MAX words), then ownership rotates. Tracks its own
//                FIFO occupancy because the FIFO full flag lags a cycle.
//  Ports       : clock, resetn     clock / async active-low reset
//                req[N]            requester has a valid word
//                req_data[N*8]     requester i word at [8*i+7:8*i]
//                req_last[N]       current word ends the packet
//                gnt[N]            combinational one-hot accept
//                fifo_read_enb     consumer read strobe (monitor only)
//                write_enb         registered FIFO write strobe
//                data_in[8]        registered FIFO write data
//                level[AW+1]       accepted-minus-read word count
//                busy              burst owner locked
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N          = 4,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int BURST_MAX  = 4
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [N-1:0]          req,
    input  logic [N*8-1:0]        req_data,
    input  logic [N-1:0]          req_last,
    output logic [N-1:0]          gnt,
    input  logic                  fifo_read_enb,
    output logic                  write_enb,
    output logic [7:0]            data_in,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  busy
);

    localparam int PW = clog2(N);
    localparam int BW = clog2(BURST_MAX + 1);

    localparam logic [ADDR_WIDTH:0] DEPTH_L   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [BW-1:0]       BMAX_L    = BW'(BURST_MAX);
    localparam logic [PW-1:0]       LAST_IDX  = PW'(N - 1);

    arb_state_t          state, state_nxt;
    logic [PW-1:0]       rr_ptr, rr_ptr_nxt;
    logic [PW-1:0]       owner, owner_nxt;
    logic [BW-1:0]       beat_cnt, beat_nxt;
    logic [ADDR_WIDTH:0] level_nxt;

    logic                space;
    logic                accept;
    logic                rd;
    logic [PW-1:0]       acc_idx;
    logic [7:0]          acc_word;
    logic                pick_found;
    logic [PW-1:0]       pick_idx;

    // Modulo-N increment by compare-and-clear; correct for any N.
    function automatic logic [PW-1:0] inc_mod(input logic [PW-1:0] x);
        return (x == LAST_IDX) ? '0 : x + 1'b1;
    endfunction

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_rr_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Strictly less than DEPTH: a same-cycle read never frees a slot for an
    // accept, since the FIFO itself still reports full in that cycle.
    assign space = (level < DEPTH_L);
    assign rd    = fifo_read_enb && (level != '0);

    // Next-state, grant and accept decode.
    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        owner_nxt  = owner;
        beat_nxt   = beat_cnt;
        gnt        = '0;
        accept     = 1'b0;
        acc_idx    = owner;

        // gnt is combinational, so it must be forced low while reset is held
        // rather than waiting for the registers to be cleared.
        if (resetn) begin
            case (state)
                IDLE: begin
                    if (pick_found && space) begin
                        gnt[pick_idx] = 1'b1;
                        accept        = 1'b1;
                        acc_idx       = pick_idx;
                        owner_nxt     = pick_idx;
                        beat_nxt      = BW'(1);
                        if (req_last[pick_idx] || (BURST_MAX == 1)) begin
                            rr_ptr_nxt = inc_mod(pick_idx);
                        end else begin
                            state_nxt = BURST;
                        end
                    end
                end
                BURST: begin
                    if (req[owner] && space) begin
                        gnt[owner] = 1'b1;
                        accept     = 1'b1;
                        beat_nxt   = beat_cnt + 1'b1;
                        if (req_last[owner] || ((beat_cnt + 1'b1) == BMAX_L)) begin
                            state_nxt  = IDLE;
                            rr_ptr_nxt = inc_mod(owner);
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Select the accepted requester's word.
    always_comb begin
        acc_word = '0;
        for (int i = 0; i < N; i++) begin
            if (acc_idx == PW'(i)) begin
                acc_word = req_data[8*i +: 8];
            end
        end
    end

    // Occupancy: accept and read in the same cycle cancel out.
    always_comb begin
        level_nxt = level;
        case ({accept, rd})
            2'b10:   level_nxt = level + 1'b1;
            2'b01:   level_nxt = level - 1'b1;
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            beat_cnt  <= '0;
            level     <= '0;
            write_enb <= 1'b0;
            data_in   <= 8'h00;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            owner     <= owner_nxt;
            beat_cnt  <= beat_nxt;
            level     <= level_nxt;
            write_enb <= accept;
            busy      <= (state_nxt == BURST);
            if (accept) begin
                data_in <= acc_word;
            end
        end
    end

endmodule : fifo_wr_arbiter
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_wr_arbiter
//  Description : Directed self-checking bench for fifo_wr_arbiter. Expected
//                write words are queued when a grant is expected and popped
//                when the registered write strobe is due.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    logic        clock = 1'b0;
    logic        resetn;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  gnt;
    logic        fifo_read_enb;
    logic        write_enb;
    logic [7:0]  data_in;
    logic [2:0]  level;
    logic        busy;

    int          n_pass  = 0;
    int          n_total = 0;
    int          m_level = 0;
    logic [7:0]  sb[$];

    always #5 clock = ~clock;

    fifo_wr_arbiter #(
        .N          (4),
        .DEPTH      (4),
        .ADDR_WIDTH (2),
        .BURST_MAX  (4)
    ) dut (
        .clock         (clock),
        .resetn        (resetn),
        .req           (req),
        .req_data      (req_data),
        .req_last      (req_last),
        .gnt           (gnt),
        .fifo_read_enb (fifo_read_enb),
        .write_enb     (write_enb),
        .data_in       (data_in),
        .level         (level),
        .busy          (busy)
    );

    function automatic logic [31:0] dw(input logic [7:0] b);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock cycle: drive inputs, check at the falling edge, update model.
    task automatic step(input logic [3:0] r, input logic [31:0] d, input logic [3:0] l,
                        input logic rdn, input logic [3:0] eg, input logic eb);
        int acc;
        int rdv;
        req           = r;
        req_data      = d;
        req_last      = l;
        fifo_read_enb = rdn;
        @(negedge clock);
        if (sb.size() > 0) begin
            chk("write_enb", 32'(write_enb), 32'd1);
            chk("data_in", 32'(data_in), 32'(sb.pop_front()));
        end else begin
            chk("write_enb", 32'(write_enb), 32'd0);
        end
        chk("level", 32'(level), m_level);
        chk("busy", 32'(busy), 32'(eb));
        chk("gnt", 32'(gnt), 32'(eg));
        for (int i = 0; i < 4; i++) begin
            if (eg[i] && r[i]) sb.push_back(d[8*i +: 8]);
        end
        acc     = (|(eg & r)) ? 1 : 0;
        rdv     = (rdn && (m_level != 0)) ? 1 : 0;
        m_level = m_level + acc - rdv;
        @(posedge clock);
        #1;
    endtask

    initial begin
        resetn        = 1'b0;
        req           = 4'hF;
        req_last      = 4'hF;
        req_data      = dw(8'hA0);
        fifo_read_enb = 1'b0;

        // Reset state with all requesters active
        @(negedge clock);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_write_enb", 32'(write_enb), 32'd0);
        chk("rst_data_in", 32'(data_in), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clock);
        #1;
        resetn = 1'b1;

        // Single-word packets walk 0,1,2,3
        step(4'hF, dw(8'h10), 4'hF, 1'b0, 4'b0001, 1'b0);
        step(4'hF, dw(8'h20), 4'hF, 1'b1, 4'b0010, 1'b0);
        step(4'hF, dw(8'h30), 4'hF, 1'b1, 4'b0100, 1'b0);
        step(4'hF, dw(8'h40), 4'hF, 1'b1, 4'b1000, 1'b0);
        step(4'h0, dw(8'h50), 4'h0, 1'b1, 4'b0000, 1'b0);
        step(4'h0, dw(8'h50), 4'h0, 1'b1, 4'b0000, 1'b0); // read at level 0

        // Burst lock: req0 three words while req1 waits; read+accept at level 2
        step(4'h3, dw(8'h60), 4'h2, 1'b0, 4'b0001, 1'b0);
        step(4'h3, dw(8'h70), 4'h2, 1'b0, 4'b0001, 1'b1);
        step(4'h3, dw(8'h80), 4'h3, 1'b1, 4'b0001, 1'b1);
        step(4'h2, dw(8'h90), 4'h2, 1'b0, 4'b0010, 1'b0);
        step(4'h0, dw(8'h90), 4'h0, 1'b1, 4'b0000, 1'b0);
        step(4'h0, dw(8'h90), 4'h0, 1'b1, 4'b0000, 1'b0);
        step(4'h0, dw(8'h90), 4'h0, 1'b1, 4'b0000, 1'b0);

        // Forced rotation after BURST_MAX words from req2; req3 wins next
        step(4'hC, dw(8'hA0), 4'h8, 1'b1, 4'b0100, 1'b0);
        step(4'hC, dw(8'hB0), 4'h8, 1'b1, 4'b0100, 1'b1);
        step(4'hC, dw(8'hC0), 4'h8, 1'b1, 4'b0100, 1'b1);
        step(4'hC, dw(8'hD0), 4'h8, 1'b1, 4'b0100, 1'b1);
        step(4'hC, dw(8'hE0), 4'h8, 1'b1, 4'b1000, 1'b0);
        step(4'h0, dw(8'hE0), 4'h0, 1'b1, 4'b0000, 1'b0);

        // Fill without reads; full blocks grants even alongside a read
        step(4'hF, dw(8'h14), 4'hF, 1'b0, 4'b0001, 1'b0);
        step(4'hF, dw(8'h24), 4'hF, 1'b0, 4'b0010, 1'b0);
        step(4'hF, dw(8'h34), 4'hF, 1'b0, 4'b0100, 1'b0);
        step(4'hF, dw(8'h44), 4'hF, 1'b0, 4'b1000, 1'b0);
        step(4'hF, dw(8'h54), 4'hF, 1'b0, 4'b0000, 1'b0);
        step(4'hF, dw(8'h64), 4'hF, 1'b1, 4'b0000, 1'b0);
        step(4'hF, dw(8'h74), 4'hF, 1'b0, 4'b0001, 1'b0);
        step(4'h0, dw(8'h74), 4'h0, 1'b1, 4'b0000, 1'b0);
        step(4'h0, dw(8'h74), 4'h0, 1'b1, 4'b0000, 1'b0);
        step(4'h0, dw(8'h74), 4'h0, 1'b1, 4'b0000, 1'b0);
        step(4'h0, dw(8'h74), 4'h0, 1'b1, 4'b0000, 1'b0);

        // Reset in the middle of a burst owned by req1 (after beat 2)
        step(4'h2, dw(8'h18), 4'h0, 1'b0, 4'b0010, 1'b0);
        step(4'h2, dw(8'h28), 4'h0, 1'b0, 4'b0010, 1'b1);
        req = 4'h3;
        #1;
        resetn = 1'b0;
        #1;
        chk("midrst_gnt", 32'(gnt), 32'd0);
        chk("midrst_write_enb", 32'(write_enb), 32'd0);
        chk("midrst_data_in", 32'(data_in), 32'd0);
        chk("midrst_level", 32'(level), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        sb.delete();
        m_level = 0;
        req     = 4'h0;
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        step(4'h3, dw(8'h38), 4'h3, 1'b0, 4'b0001, 1'b0);
        step(4'h2, dw(8'h48), 4'h2, 1'b0, 4'b0010, 1'b0);
        step(4'h0, dw(8'h48), 4'h0, 1'b0, 4'b0000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_fifo_wr_arbiter
`default_nettype wire
